multiplier_datapath_taint_track_bitwise: RTL and testbench
==========================================================

Name: multiplier_datapath_taint_track_bitwise

Overview:
- Datapath half of the sequential shift-add multiplier, with bitwise taint tracking (information-flow shadow bits).
- Consumes the control strobes rsload/rsclear/rsshr/mrld/mdld and their taint bits from the multiplier control FSM.
- Returns multiplierReg and multiplierReg_t to the control FSM.
- Every stored value bit carries a shadow taint bit, updated each cycle by the precise/conservative rules below.

Parameters:
- WIDTH, 4, operand width in bits; the product is 2*WIDTH bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- a  in  WIDTH  multiplicand operand
- a_t  in  WIDTH  taint of a
- b  in  WIDTH  multiplier operand
- b_t  in  WIDTH  taint of b
- mdld, mdld_t  in  1,1  load multiplicand register (md) from a; taint of the strobe
- mrld, mrld_t  in  1,1  load multiplier register (mr) from b; taint of the strobe
- rsclear, rsclear_t  in  1,1  clear the running-sum register (rs); taint of the strobe
- rsload, rsload_t  in  1,1  add md into the upper part of rs; taint of the strobe
- rsshr, rsshr_t  in  1,1  shift rs right by 1; taint of the strobe
- multiplierReg  out  WIDTH  current mr value, to control
- multiplierReg_t  out  WIDTH  taint of mr
- product  out  2*WIDTH  rs[2*WIDTH-1:0]
- product_t  out  2*WIDTH  taint of product

Behaviour:
- Registers and shadows:
  - md[WIDTH-1:0] with md_t.
  - mr[WIDTH-1:0] with mr_t.
  - rs[2*WIDTH:0] with rs_t. The extra MSB holds the add carry.
- Reset (async, rst=1): md, mr, rs and all taint registers go to 0 immediately. All outputs read 0. Reset mid-multiply abandons the operation; there is no residual taint.
- Outputs are combinational from registers; there is no output latency beyond the register.
- md and mr each update independently and may load in the same cycle.
- rs operation priority in a cycle: rsclear > rsload > rsshr. Only the highest asserted one takes effect.
- Nominal next values:
  - clear: rs <= 0.
  - add: rs[2W:W] <= rs[2W:W] + {1'b0, md}, computed at W+1 bits. A carry out of bit 2W cannot occur for a legal sequence and is dropped. rs[W-1:0] is unchanged.
  - shift: rs <= {1'b0, rs[2W:1]}.
- Generic taint rule for any register R, with selected next value D, D's taint D_t, enable en and enable taint en_t:
  - en=1: R_t <= D_t | {en_t}.
  - en=0, en_t=1: R_t <= R_t | D_t | (R ^ D). Bits that would differ become tainted.
  - en=0, en_t=0: R_t unchanged.
- For rs, the rule is applied per operation in priority order. The effective en_t of the chosen operation is OR-ed with the taints of all higher-priority strobes.
- Taint of each candidate D:
  - clear: D_t = 0.
  - shift: D_t = {1'b0, rs_t[2W:1]}.
  - add: let t = rs_t[2W:W] | {1'b0, md_t}. Sum taint bit i = |t[i:0], i.e. carry propagates taint upward. Lower W bits keep rs_t[W-1:0].
- md/mr candidates: D=a, D_t=a_t; D=b, D_t=b_t.
- Boundaries:
  - md=all-ones, mr=all-ones gives the maximum product; the sum fits in W+1 bits.
  - WIDTH=1 must elaborate.
  - Untainted inputs and strobes must never produce any taint bit.

Decomposition:
- Shared package (multiplier_pkg): the WIDTH default and the rs width expression RS_WIDTH = 2*WIDTH+1.
- One sub-module is natural: taint_reg_update, parameterised by width. It implements the generic R/R_t update rule and is instantiated for md, mr and rs.
- The carry-propagating add-taint function lives in the top module.

Test Plan:
- WIDTH=4, a=13, b=11, untainted. Drive INIT (mdld, mrld, rsclear), then 4 × (rsload if b[i]) + rsshr → product=143, product_t=0, multiplierReg=11.
- Same sequence with a_t=4'b0001 → product_t nonzero only at and above the first bit where md bit0 entered a sum, i.e. tainted bits form the upward-closed masks predicted by the carry rule (compare against a reference model).
- b_t=4'b0100, a=5, b=6 → multiplierReg_t=4'b0100 immediately after mrld. product_t=0 if the control strobes stay untainted.
- rsload=0 with rsload_t=1, rs=0, md=3 → rs_t[W+1:W]=2'b11 (bits that would change). Other bits stay 0.
- rsclear and rsshr both asserted → rs=0 and rs_t=0 (clear wins).
- Assert rst asynchronously mid-multiply, with no clock edge → all outputs and taints go to 0 within the same cycle. A subsequent 3×3 multiply gives 9.

Source files
------------

// File: rtl/multiplier_pkg.sv
// rtl/multiplier_pkg.sv - shared widths for the taint-tracking shift-add multiplier datapath
package multiplier_pkg;

  // Operand width used when a block is instantiated without an override.
  localparam int DEFAULT_WIDTH = 4;

  // Running sum is two operands wide plus one carry bit.
  localparam int RS_WIDTH = 2 * DEFAULT_WIDTH + 1;

  // Running-sum width for an arbitrary operand width.
  function automatic int rs_width(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/multiplier_datapath_taint_track_bitwise_if.sv
// rtl/multiplier_datapath_taint_track_bitwise_if.sv - operand/strobe/result bundle between control and datapath
interface multiplier_datapath_taint_track_bitwise_if
  import multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   a_t;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   b_t;
  logic               mdld;
  logic               mdld_t;
  logic               mrld;
  logic               mrld_t;
  logic               rsclear;
  logic               rsclear_t;
  logic               rsload;
  logic               rsload_t;
  logic               rsshr;
  logic               rsshr_t;
  logic [WIDTH-1:0]   multiplierReg;
  logic [WIDTH-1:0]   multiplierReg_t;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_t;

  // Control side: drives operands and strobes, observes mr and the product.
  modport master (
    output a, a_t, b, b_t,
    output mdld, mdld_t, mrld, mrld_t,
    output rsclear, rsclear_t, rsload, rsload_t, rsshr, rsshr_t,
    input  multiplierReg, multiplierReg_t, product, product_t
  );

  // Datapath side.
  modport slave (
    input  a, a_t, b, b_t,
    input  mdld, mdld_t, mrld, mrld_t,
    input  rsclear, rsclear_t, rsload, rsload_t, rsshr, rsshr_t,
    output multiplierReg, multiplierReg_t, product, product_t
  );
endinterface

// File: rtl/taint_reg_update.sv
// rtl/taint_reg_update.sv - value register with shadow taint bits under an enable/enable-taint rule
module taint_reg_update #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_en_t,
  input  logic [W-1:0] i_d,
  input  logic [W-1:0] i_d_t,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_q_t
);
  logic [W-1:0] r_q;
  logic [W-1:0] r_q_t;

  // Load on enable; a tainted but inactive enable taints every bit that could have changed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= '0;
      r_q_t <= '0;
    end else if (i_en) begin
      r_q   <= i_d;
      r_q_t <= i_d_t | {W{i_en_t}};
    end else if (i_en_t) begin
      r_q_t <= r_q_t | i_d_t | (r_q ^ i_d);
    end
  end

  assign o_q   = r_q;
  assign o_q_t = r_q_t;
endmodule

// File: rtl/multiplier_datapath_taint_track_bitwise.sv
// rtl/multiplier_datapath_taint_track_bitwise.sv - shift-add multiplier datapath with bitwise taint tracking
module multiplier_datapath_taint_track_bitwise
  import multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic clk,
  input logic rst,
  multiplier_datapath_taint_track_bitwise_if.slave bus
);
  localparam int RSW = rs_width(WIDTH);

  logic [WIDTH-1:0] w_md, w_md_t, w_mr, w_mr_t;
  logic [RSW-1:0]   w_rs, w_rs_t;
  logic [WIDTH:0]   w_sum;
  logic [RSW-1:0]   w_add_d, w_add_dt, w_shr_d, w_shr_dt;
  logic [RSW-1:0]   w_rs_d, w_rs_dt;
  logic             w_ld_et, w_shr_et, w_rs_en, w_rs_et;

  // Taint spreads upward through the carry chain: a sum bit is tainted if any bit at or below it is.
  function automatic logic [WIDTH:0] add_taint(input logic [WIDTH:0] t);
    logic [WIDTH:0] r;
    r[0] = t[0];
    for (int i = 1; i <= WIDTH; i++) begin
      r[i] = r[i-1] | t[i];
    end
    return r;
  endfunction

  taint_reg_update #(.W(WIDTH)) u_md (
    .clk(clk), .rst(rst), .i_en(bus.mdld), .i_en_t(bus.mdld_t),
    .i_d(bus.a), .i_d_t(bus.a_t), .o_q(w_md), .o_q_t(w_md_t)
  );

  taint_reg_update #(.W(WIDTH)) u_mr (
    .clk(clk), .rst(rst), .i_en(bus.mrld), .i_en_t(bus.mrld_t),
    .i_d(bus.b), .i_d_t(bus.b_t), .o_q(w_mr), .o_q_t(w_mr_t)
  );

  taint_reg_update #(.W(RSW)) u_rs (
    .clk(clk), .rst(rst), .i_en(w_rs_en), .i_en_t(w_rs_et),
    .i_d(w_rs_d), .i_d_t(w_rs_dt), .o_q(w_rs), .o_q_t(w_rs_t)
  );

  // Pick the running-sum candidate by clear > load > shift; with no strobe active, fold every
  // candidate whose (cumulative) strobe taint is set into the taint input and hold the value.
  always_comb begin
    w_sum    = w_rs[RSW-1:WIDTH] + {1'b0, w_md};
    w_add_d  = {w_sum, w_rs[WIDTH-1:0]};
    w_add_dt = {add_taint(w_rs_t[RSW-1:WIDTH] | {1'b0, w_md_t}), w_rs_t[WIDTH-1:0]};
    w_shr_d  = {1'b0, w_rs[RSW-1:1]};
    w_shr_dt = {1'b0, w_rs_t[RSW-1:1]};
    w_ld_et  = bus.rsclear_t | bus.rsload_t;
    w_shr_et = w_ld_et | bus.rsshr_t;
    w_rs_en  = bus.rsclear | bus.rsload | bus.rsshr;
    w_rs_d   = w_rs;
    w_rs_dt  = '0;
    w_rs_et  = 1'b0;
    if (bus.rsclear) begin
      w_rs_d  = '0;
      w_rs_et = bus.rsclear_t;
    end else if (bus.rsload) begin
      w_rs_d  = w_add_d;
      w_rs_dt = w_add_dt;
      w_rs_et = w_ld_et;
    end else if (bus.rsshr) begin
      w_rs_d  = w_shr_d;
      w_rs_dt = w_shr_dt;
      w_rs_et = w_shr_et;
    end else begin
      w_rs_et = w_shr_et;
      if (bus.rsclear_t) begin
        w_rs_dt = w_rs_dt | w_rs;
      end
      if (w_ld_et) begin
        w_rs_dt = w_rs_dt | w_add_dt | (w_rs ^ w_add_d);
      end
      if (w_shr_et) begin
        w_rs_dt = w_rs_dt | w_shr_dt | (w_rs ^ w_shr_d);
      end
    end
  end

  assign bus.multiplierReg   = w_mr;
  assign bus.multiplierReg_t = w_mr_t;
  assign bus.product         = w_rs[2*WIDTH-1:0];
  assign bus.product_t       = w_rs_t[2*WIDTH-1:0];
endmodule

// File: tb/tb_multiplier_datapath_taint_track_bitwise.sv
// tb/tb_multiplier_datapath_taint_track_bitwise.sv - randomized self-checking bench for the taint-tracking datapath
module tb_multiplier_datapath_taint_track_bitwise;
  import multiplier_pkg::*;

  localparam int W    = 4;
  localparam int RSW  = RS_WIDTH;
  localparam int ALL  = (1 << RSW) - 1;
  localparam int LOW  = (1 << W) - 1;
  localparam int PMSK = (1 << (2 * W)) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multiplier_datapath_taint_track_bitwise_if #(.WIDTH(W)) bus ();
  multiplier_datapath_taint_track_bitwise #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  multiplier_datapath_taint_track_bitwise_if #(.WIDTH(1)) bus1 ();
  multiplier_datapath_taint_track_bitwise #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_vec = 0;
  int n_err = 0;

  int va, va_t, vb, vb_t;
  int m_md, m_md_t, m_mr, m_mr_t, m_rs, m_rs_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int upmask(input int t);
    if (t == 0) return 0;
    return ((1 << (W + 1)) - 1) & ~((t & -t) - 1);
  endfunction

  task automatic gen_rule(input int r, input int rt, input bit en, input bit et,
                          input int d, input int dt, input int msk,
                          output int nr, output int nrt);
    nr  = r;
    nrt = rt;
    if (en) begin
      nr  = d;
      nrt = dt | (et ? msk : 0);
    end else if (et) begin
      nrt = rt | dt | (r ^ d);
    end
  endtask

  // s/st index: 0 clear, 1 load, 2 shift (priority order)
  task automatic model_step(input bit mdld, input bit mdld_t, input bit mrld, input bit mrld_t,
                            input bit [2:0] s, input bit [2:0] st);
    int d[3];
    int dt[3];
    int nr, nrt, hi, lo;
    bit et;
    bit taken;
    hi = m_rs >> W;
    lo = m_rs & LOW;
    d[0]  = 0;
    dt[0] = 0;
    d[1]  = (((hi + m_md) % (1 << (W + 1))) << W) | lo;
    dt[1] = (upmask((m_rs_t >> W) | m_md_t) << W) | (m_rs_t & LOW);
    d[2]  = m_rs >> 1;
    dt[2] = m_rs_t >> 1;
    et = 1'b0;
    taken = 1'b0;
    nr = m_rs;
    nrt = m_rs_t;
    for (int k = 0; k < 3; k++) begin
      et = et | st[k];
      if (!taken && s[k]) begin
        gen_rule(m_rs, m_rs_t, 1'b1, et, d[k], dt[k], ALL, nr, nrt);
        taken = 1'b1;
      end
    end
    if (!taken) begin
      et = 1'b0;
      for (int k = 0; k < 3; k++) begin
        et = et | st[k];
        if (et) nrt = nrt | dt[k] | (m_rs ^ d[k]);
      end
    end
    gen_rule(m_md, m_md_t, mdld, mdld_t, va, va_t, LOW, m_md, m_md_t);
    gen_rule(m_mr, m_mr_t, mrld, mrld_t, vb, vb_t, LOW, m_mr, m_mr_t);
    m_rs = nr;
    m_rs_t = nrt;
  endtask

  task automatic model_reset();
    m_md = 0; m_md_t = 0; m_mr = 0; m_mr_t = 0; m_rs = 0; m_rs_t = 0;
  endtask

  task automatic idle_inputs();
    bus.mdld = 0; bus.mdld_t = 0; bus.mrld = 0; bus.mrld_t = 0;
    bus.rsclear = 0; bus.rsclear_t = 0; bus.rsload = 0; bus.rsload_t = 0;
    bus.rsshr = 0; bus.rsshr_t = 0;
  endtask

  task automatic check_all();
    check("mr", bus.multiplierReg, m_mr);
    check("mr_t", bus.multiplierReg_t, m_mr_t);
    check("product", bus.product, m_rs & PMSK);
    check("product_t", bus.product_t, m_rs_t & PMSK);
  endtask

  task automatic cycle(input bit mdld, input bit mdld_t, input bit mrld, input bit mrld_t,
                       input bit [2:0] s, input bit [2:0] st);
    bus.a = va[W-1:0]; bus.a_t = va_t[W-1:0]; bus.b = vb[W-1:0]; bus.b_t = vb_t[W-1:0];
    bus.mdld = mdld; bus.mdld_t = mdld_t; bus.mrld = mrld; bus.mrld_t = mrld_t;
    bus.rsclear = s[0]; bus.rsload = s[1]; bus.rsshr = s[2];
    bus.rsclear_t = st[0]; bus.rsload_t = st[1]; bus.rsshr_t = st[2];
    @(posedge clk);
    model_step(mdld, mdld_t, mrld, mrld_t, s, st);
    #1;
    check_all();
  endtask

  // Full multiply as the control FSM would sequence it; st taints every strobe it issues.
  task automatic multiply(input int a, input int at, input int b, input int bt, input bit [2:0] st);
    va = a; va_t = at; vb = b; vb_t = bt;
    cycle(1'b1, st[0], 1'b1, st[0], 3'b001, st);
    for (int i = 0; i < W; i++) begin
      if (b[i]) cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'b010, st);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'b100, st);
    end
  endtask

  initial begin
    model_reset();
    va = 0; va_t = 0; vb = 0; vb_t = 0;
    bus.a = 0; bus.a_t = 0; bus.b = 0; bus.b_t = 0;
    idle_inputs();
    bus1.a = 0; bus1.a_t = 0; bus1.b = 0; bus1.b_t = 0;
    bus1.mdld = 0; bus1.mdld_t = 0; bus1.mrld = 0; bus1.mrld_t = 0;
    bus1.rsclear = 0; bus1.rsclear_t = 0; bus1.rsload = 0; bus1.rsload_t = 0;
    bus1.rsshr = 0; bus1.rsshr_t = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    check_all();

    // WIDTH=1: 1 x 1
    @(posedge clk); #1;
    bus1.a = 1; bus1.b = 1; bus1.mdld = 1; bus1.mrld = 1; bus1.rsclear = 1;
    @(posedge clk); #1;
    bus1.mdld = 0; bus1.mrld = 0; bus1.rsclear = 0; bus1.rsload = 1;
    @(posedge clk); #1;
    bus1.rsload = 0; bus1.rsshr = 1;
    @(posedge clk); #1;
    bus1.rsshr = 0;
    check("w1_product", bus1.product, 32'd1);
    check("w1_product_t", bus1.product_t, 32'd0);

    // 13 x 11 untainted
    multiply(13, 0, 11, 0, 3'b000);
    check("p13x11", bus.product, 32'd143);
    check("p13x11_t", bus.product_t, 32'd0);
    check("mr11", bus.multiplierReg, 32'd11);

    // same with md bit0 tainted
    multiply(13, 1, 11, 0, 3'b000);
    check("p13x11_taint_nonzero", (bus.product_t != 0), 32'd1);

    // clear beats shift, wiping taint
    va = 0; va_t = 0; vb = 0; vb_t = 0;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 3'b000);
    check("clr_wins", bus.product, 32'd0);
    check("clr_wins_t", bus.product_t, 32'd0);

    // tainted mr operand
    multiply(5, 0, 6, 4'b0100, 3'b000);
    check("mr_t_0100", bus.multiplierReg_t, 32'h4);
    check("p5x6", bus.product, 32'd30);
    check("p5x6_t", bus.product_t, 32'd0);

    // inactive but tainted rsload with rs=0, md=3
    va = 3; va_t = 0; vb = 0; vb_t = 0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 3'b000);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b010);
    check("ld_taint_only", bus.product_t, 32'h30);
    check("ld_taint_val", bus.product, 32'd0);

    // asynchronous reset mid-multiply, no clock edge
    va = 9; va_t = 4'hf; vb = 7; vb_t = 4'hf;
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 3'b001, 3'b000);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 3'b010);
    #2 rst = 1'b1;
    idle_inputs();
    #1;
    model_reset();
    check_all();
    #2 rst = 1'b0;
    multiply(3, 0, 3, 0, 3'b000);
    check("p3x3", bus.product, 32'd9);

    // random full multiplies, occasionally with tainted operands/strobes
    for (int n = 0; n < 40; n++) begin
      bit [2:0] st;
      st = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      multiply($urandom_range(0, LOW), ($urandom_range(0, 1) == 1) ? $urandom_range(0, LOW) : 0,
               $urandom_range(0, LOW), ($urandom_range(0, 1) == 1) ? $urandom_range(0, LOW) : 0, st);
    end

    // random unstructured strobe traffic
    for (int n = 0; n < 150; n++) begin
      va = $urandom_range(0, LOW); va_t = $urandom_range(0, LOW);
      vb = $urandom_range(0, LOW); vb_t = $urandom_range(0, LOW);
      cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
            ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
